msx_audio_mixer: RTL

Parametrised N-channel audio mixer that replaces the fixed PSG+keyclick+cassette+slot summing and 3-bit compressor LUT in the MSX top level. It snapshots all channel samples on a sample strobe and accumulates them one channel per clock with a per-channel gain. It then saturates to a signed output word and raises a one-cycle valid pulse. It sits between the sound sources (jt49 PSG, slot sound, keybeep, cassette) and the `audio` output of the core.

---
 rtl/msx_audio_pkg.sv | 20 ++
 rtl/msx_sat_clip.sv | 30 +++
 rtl/msx_audio_mixer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/msx_audio_pkg.sv
// Shared constants, FSM state type and accumulator sizing for the MSX audio mixer.
package msx_audio_pkg;

    localparam int unsigned FRAC_BITS  = 3;
    localparam int unsigned GAIN_UNITY = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mix_state_t;

    // Worst-case sum of NUM_CH products of an (IN_W+1)-bit sample and a GAIN_W-bit gain.
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned gain_w,
                                              input int unsigned num_ch);
        return in_w + gain_w + 1 + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/msx_sat_clip.sv
// Combinational arithmetic right shift followed by signed saturation to OUT_W bits.
module msx_sat_clip #(
    parameter int unsigned IN_W  = 24,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 3
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic        [OUT_W-1:0] sat_c,
    output logic                    clip_c
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(64'sd1 <<< (OUT_W - 1)));

    logic signed [IN_W-1:0] res;

    always_comb begin
        res    = acc >>> SHIFT;
        sat_c  = res[OUT_W-1:0];
        clip_c = 1'b0;
        if (res > MAX_V) begin
            sat_c  = MAX_V[OUT_W-1:0];
            clip_c = 1'b1;
        end else if (res < MIN_V) begin
            sat_c  = MIN_V[OUT_W-1:0];
            clip_c = 1'b1;
        end
    end

endmodule

// File: rtl/msx_audio_mixer.sv
// N-channel audio mixer: snapshot on sample_en, serial per-channel gain MAC,
// then shift/saturate into a registered signed output with a one-cycle valid.
module msx_audio_mixer
    import msx_audio_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned GAIN_W = 5,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_en,
    input  logic [NUM_CH*IN_W-1:0]     ch_in,
    input  logic [NUM_CH-1:0]          ch_signed,
    input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
    input  logic                       clip_clr,
    output logic [OUT_W-1:0]           audio_out,
    output logic                       audio_valid,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun
);

    localparam int unsigned ACC_W  = acc_width(IN_W, GAIN_W, NUM_CH);
    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PROD_W = IN_W + GAIN_W + 2;

    mix_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic [IN_W-1:0]         snap_s [NUM_CH];
    logic [GAIN_W-1:0]       snap_g [NUM_CH];
    logic [NUM_CH-1:0]       snap_sg;

    logic signed [IN_W:0]    samp_x_c;
    logic signed [GAIN_W:0]  gain_x_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [OUT_W-1:0]        sat_c;
    logic                    clip_c;

    // Current channel product: sample extended per its signedness, gain always unsigned.
    always_comb begin
        samp_x_c = snap_sg[idx] ? $signed({snap_s[idx][IN_W-1], snap_s[idx]})
                                : $signed({1'b0, snap_s[idx]});
        gain_x_c = $signed({1'b0, snap_g[idx]});
        prod_c   = PROD_W'(samp_x_c) * PROD_W'(gain_x_c);
    end

    msx_sat_clip #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (FRAC_BITS)
    ) u_sat (
        .acc    (acc),
        .sat_c  (sat_c),
        .clip_c (clip_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            snap_sg     <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            busy        <= 1'b0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_s[k] <= '0;
                snap_g[k] <= '0;
            end
        end else begin
            audio_valid <= 1'b0;

            // Sticky flags: clear wins over a same-cycle set.
            if (clip_clr)
                clip <= 1'b0;
            else if (state == SAT && clip_c)
                clip <= 1'b1;

            if (clip_clr)
                overrun <= 1'b0;
            else if (sample_en && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (sample_en) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            snap_s[k] <= ch_in[k*IN_W +: IN_W];
                            snap_g[k] <= ch_gain[k*GAIN_W +: GAIN_W];
                        end
                        snap_sg <= ch_signed;
                        acc     <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(prod_c);
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_CH - 1))
                        state <= SAT;
                end
                SAT: begin
                    audio_out   <= sat_c;
                    audio_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
